// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for the EX/MEM pipeline stage.
//   invalid/inready/inctrl/indata     : upstream (EX) side
//   outvalid/outready/outctrl/outdata : downstream (MEM) side
// The stage itself connects through the slave modport; the surrounding
// pipeline (or a testbench) uses the master modport.
interface pipe_stage_skid_if #(
  parameter int CWIDTH = 11,
  parameter int PWIDTH = 205
);
  logic              invalid;
  logic              inready;
  logic [CWIDTH-1:0] inctrl;
  logic [PWIDTH-1:0] indata;
  logic              outvalid;
  logic              outready;
  logic [CWIDTH-1:0] outctrl;
  logic [PWIDTH-1:0] outdata;

  modport slave (
    input  invalid, inctrl, indata, outready,
    output inready, outvalid, outctrl, outdata
  );

  modport master (
    output invalid, inctrl, indata, outready,
    input  inready, outvalid, outctrl, outdata
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// EX/MEM pipeline-stage register with valid/ready handshake and a 2-entry
// skid buffer. inready comes straight from a register (no outready->inready
// path). flush kills all held entries and the current input; outctrl is
// forced to zero on bubbles. stallcnt saturates on backpressure cycles.
// Ports:
//   clk      : rising-edge clock
//   rstn     : synchronous active-low reset (overrides flush/handshake)
//   flush    : synchronous kill of held entries and current input
//   bus      : handshake bundle (slave side)
//   stallcnt : saturating count of cycles with outvalid=1, outready=0
module pipe_stage_skid #(
  parameter int CWIDTH   = 11,
  parameter int PWIDTH   = 205,
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [CNTWIDTH-1:0] stallcnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  logic              main_valid;
  logic [CWIDTH-1:0] main_ctrl;
  logic [PWIDTH-1:0] main_data;
  logic              skid_valid;
  logic [CWIDTH-1:0] skid_ctrl;
  logic [PWIDTH-1:0] skid_data;

  state_t state;
  logic   accept;
  logic   drain;

  // State is carried by the two valid bits; this is only a decoded view.
  always_comb begin
    state = EMPTY;
    if (main_valid) state = skid_valid ? FULL : ONE;
  end

  assign bus.inready  = ~skid_valid;
  assign bus.outvalid = main_valid;
  assign bus.outctrl  = main_valid ? main_ctrl : '0;
  assign bus.outdata  = main_data;

  assign accept = bus.invalid & ~skid_valid;
  assign drain  = main_valid & bus.outready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      stallcnt   <= '0;
    end else begin
      // Counted independently of flush: a stalled cycle is a stalled cycle.
      if (main_valid && !bus.outready && stallcnt != '1)
        stallcnt <= stallcnt + CNTWIDTH'(1);

      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              main_valid <= 1'b1;
              main_ctrl  <= bus.inctrl;
              main_data  <= bus.indata;
            end
          end
          ONE: begin
            if (accept && drain) begin
              main_ctrl <= bus.inctrl;
              main_data <= bus.indata;
            end else if (accept) begin
              skid_valid <= 1'b1;
              skid_ctrl  <= bus.inctrl;
              skid_data  <= bus.indata;
            end else if (drain) begin
              main_valid <= 1'b0;
            end
          end
          FULL: begin
            if (drain) begin
              main_ctrl  <= skid_ctrl;
              main_data  <= skid_data;
              skid_valid <= 1'b0;
            end
          end
          default: begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the EX/MEM boundary; generalises the fixed EX/MEM register to arbitrary control/payload widths.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered ready, no combinational ready path), synchronous flush with bubble insertion, and a saturating stall-cycle counter.
- Sits between the EX stage (upstream) and the MEM stage (downstream). Hazard/branch logic drives flush.

Parameters:
- CWIDTH, 11, control bundle width: memwr, memrd, bbne, bbeq, bblez, bbgtz, jump, memtoreg[1:0], regwr, fin.
- PWIDTH, 205, payload width: aluout, zero/negative/overflow, regdstmux, regdata2, branaddr, jmpaddr, rt, pcnext, ins.
- CNTWIDTH, 16, stall counter width.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, synchronous, active-low.
- flush  input  1  kill all held entries and the current input.
- invalid  input  1  upstream entry valid.
- inready  output  1  stage can accept; driven directly from a register.
- inctrl  input  CWIDTH  upstream control bundle.
- indata  input  PWIDTH  upstream payload.
- outvalid  output  1  downstream entry valid.
- outready  input  1  downstream accepts.
- outctrl  output  CWIDTH  control bundle; forced to 0 when outvalid=0.
- outdata  output  PWIDTH  payload of the head entry.
- stallcnt  output  CNTWIDTH  saturating count of backpressure cycles.

Behaviour:
- Storage:
  - main entry (ctrl, data, valid) drives the outputs.
  - skid entry (ctrl, data, valid) holds the overflow entry.
  - State is encoded by the valid bits: EMPTY (0/0), ONE (1/0), FULL (1/1).
- Definitions: accept = invalid & inready; drain = outvalid & outready.
- inready = ~skid.valid, taken straight from the register. There is no path from outready to inready.
- Transitions (all on the clk rising edge, no flush):
  - EMPTY: accept -> main<=in, ONE; otherwise stay EMPTY.
  - ONE, accept & drain -> main<=in, ONE.
  - ONE, accept & ~drain -> skid<=in, FULL.
  - ONE, ~accept & drain -> EMPTY.
  - ONE, neither -> hold.
  - FULL: inready=0, so no accept. drain -> main<=skid, skid.valid<=0, ONE. Otherwise hold.
- Latency and ordering:
  - An entry accepted in cycle N is visible at the outputs in cycle N+1 at the earliest.
  - Entries leave strictly in FIFO order. There is no loss or duplication.
- Held entries: outdata and outctrl are stable while outvalid=1 and outready=0.
- Flush (synchronous):
  - Next state is EMPTY and both valid bits clear.
  - The input presented in the flush cycle is discarded even if invalid=1.
  - Data registers may retain stale values.
  - inready=1 in the cycle after a flush.
- Bubble rule: outctrl = main.ctrl when outvalid=1, else all zeros. This guarantees no regwr or memwr on a bubble. outdata is not gated.
- Reset:
  - rstn=0 at a rising edge forces EMPTY, clears all ctrl/data registers, and sets stallcnt=0.
  - Reset overrides flush and all handshakes.
  - Reset mid-transfer drops in-flight entries.
  - Outputs after reset: outvalid=0, outctrl=0, outdata=0, inready=1, stallcnt=0.
- stallcnt:
  - Increments by 1 every cycle with outvalid=1 and outready=0.
  - Saturates at 2^CNTWIDTH-1 and never wraps.
  - Cleared only by reset; flush does not affect it.
  - Counts the cycle even if a flush occurs in that cycle.
- Priority order: reset > flush > handshake.
- Width rule: widths are carried bit-for-bit; the block performs no arithmetic beyond stallcnt.

Test Plan:
- Reset, then invalid=1 with inctrl=0x401 and indata=5, and outready=1 continuously -> outvalid rises the next cycle with outdata=5 and outctrl=0x401. Streaming 1,2,3 back-to-back gives 1,2,3 on consecutive cycles with inready held at 1.
- Backpressure: entries A=0xA and B=0xB offered, outready=0 -> the stage reaches FULL, inready=0, outdata=0xA stable. stallcnt increments each cycle. Raising outready yields A then B, and inready returns to 1 one cycle after A drains.
- Flush while FULL with invalid=1 carrying C -> the next cycle shows outvalid=0, outctrl=0, inready=1. C never appears, and stallcnt keeps its value.
- Saturation with CNTWIDTH=4: hold outvalid=1 and outready=0 for 20 cycles -> stallcnt reaches 15 and stays at 15.
- Reset asserted while FULL together with flush=1 and invalid=1 -> the next cycle shows outvalid=0, outdata=0, stallcnt=0, inready=1. A subsequent accept works normally.
- Randomised valid/ready for 10k cycles against a scoreboard -> output order equals input order, no entry is dropped or duplicated, and outctrl=0 whenever outvalid=0.
